// File: rtl/msg_seq_defs.sv
// Shared definitions for the message sequencer and the display writer:
// state encodings and the display-clear command code.
package msg_seq_defs;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CLEAR_CODE = 0;

endpackage

// File: rtl/char_counter.sv
// Character index counter: synchronous clear, enable, and a
// terminal flag comparing the index to the latched length.
module char_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_len,
  output logic [W-1:0] o_cnt,
  output logic         o_term
);

  logic [W-1:0] r_cnt;
  logic         w_term;

  assign w_term = (r_cnt == i_len);

  // Saturates at the terminal value so the index never wraps
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = w_term;

endmodule

// File: rtl/msg_sequencer.sv
// Streams a clear command followed by the characters of the selected
// ROM message to a display writer over a valid/ready handshake.
module msg_sequencer
  import msg_seq_defs::*;
#(
  parameter int CHAR_W = 4,
  parameter int MSG_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MSG_W-1:0]  msg_sel,
  input  logic              abort,
  output logic [MSG_W-1:0]  msg_id,
  output logic [CHAR_W-1:0] counter_caracter,
  input  logic [CHAR_W-1:0] caracter,
  input  logic [CHAR_W-1:0] len_string,
  output logic [CHAR_W-1:0] char_out,
  output logic              out_clear,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [MSG_W-1:0]  r_msg_id;
  logic [CHAR_W-1:0] r_len;
  logic [CHAR_W-1:0] r_char;
  logic              r_clear;
  logic              r_valid;
  logic              r_done;

  logic              w_hs;
  logic              w_go;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_last;
  logic [CHAR_W-1:0] w_cnt;

  assign w_hs      = r_valid && char_ready;
  assign w_go      = (r_state == S_IDLE) && start && !abort;
  assign w_cnt_clr = w_go || ((r_state != S_IDLE) && abort);
  assign w_cnt_en  = (r_state == S_SEND) && w_hs && !abort;

  char_counter #(
    .W (CHAR_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_len  (r_len),
    .o_cnt  (w_cnt),
    .o_term (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_msg_id <= '0;
      r_len    <= '0;
      r_char   <= '0;
      r_clear  <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else if ((r_state != S_IDLE) && abort) begin
      // Abort wins over any pending handshake
      r_state <= S_IDLE;
      r_clear <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_go) begin
            r_msg_id <= msg_sel;
            r_char   <= CHAR_W'(CLEAR_CODE);
            r_clear  <= 1'b1;
            r_valid  <= 1'b1;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (w_hs) begin
            r_len   <= len_string;
            r_clear <= 1'b0;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_char  <= caracter;
          r_valid <= 1'b1;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_clear <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign msg_id           = r_msg_id;
  assign counter_caracter = w_cnt;
  assign char_out         = r_char;
  assign out_clear        = r_clear;
  assign char_valid       = r_valid;
  assign done             = r_done;
  assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_msg_sequencer.sv
// Bench for msg_sequencer: directed timing table, corner sequences
// and a randomized run against a transaction-level model.
module tb_msg_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, char_ready;
  logic [1:0] msg_sel, msg_id;
  logic [3:0] counter_caracter, caracter, len_string, char_out;
  logic       out_clear, char_valid, busy, done;

  logic [3:0] rom [0:3][0:15];
  logic [3:0] lens [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign caracter   = rom[msg_id][counter_caracter];
  assign len_string = lens[msg_id];

  msg_sequencer #(.CHAR_W(4), .MSG_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .msg_sel          (msg_sel),
    .abort            (abort),
    .msg_id           (msg_id),
    .counter_caracter (counter_caracter),
    .caracter         (caracter),
    .len_string       (len_string),
    .char_out         (char_out),
    .out_clear        (out_clear),
    .char_valid       (char_valid),
    .char_ready       (char_ready),
    .busy             (busy),
    .done             (done)
  );

  typedef struct {
    logic       v;
    logic       c;
    logic       d;
    logic       b;
    logic [3:0] ch;
  } row_t;

  row_t tbl [1:15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Start message m with ready=1; count characters and check content
  task automatic run_msg(input logic [1:0] m, input string nm,
                         output int nchar, output logic [3:0] last_idx);
    int n;
    logic [3:0] expc [0:15];
    for (int i = 0; i < 16; i++) expc[i] = rom[m][i];
    nchar = 0;
    char_ready = 1'b1;
    start = 1'b1;
    msg_sel = m;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (char_valid && !out_clear) begin
        if (nchar < 16) chk({nm, "_char"}, char_out, expc[nchar]);
        nchar++;
      end
      tick();
      n++;
      if (n == 2 && m == 2'd3) lens[3] = 4'd2;
    end
    if (!done) chk({nm, "_done_timeout"}, 32'd1, 32'd0);
    last_idx = counter_caracter;
    tick();
  endtask

  initial begin
    int nc, sd, nt;
    logic [3:0] li;
    logic [3:0] aceito [0:5];
    logic m_busy, m_final, pv, pclr, hs, st, ab, rdy;
    logic [3:0] pc;
    logic [1:0] ms;
    logic [4:0] q [$];
    logic [4:0] e;

    aceito = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd10, 4'd7};
    for (int i = 0; i < 16; i++) begin
      rom[0][i] = (i < 6) ? aceito[i] : 4'd0;
      rom[1][i] = (i == 0) ? 4'd9 : 4'd0;
      rom[2][i] = 4'(15 - i);
      rom[3][i] = 4'((i * 3 + 1) & 15);
    end
    lens[0] = 4'd5;
    lens[1] = 4'd0;
    lens[2] = 4'd15;
    lens[3] = 4'd6;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    msg_sel = 2'd0;
    char_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_state",
        {msg_id, counter_caracter, char_out, out_clear, char_valid, busy, done},
        '0);

    // ACEITO timing table, ready held high
    for (int n = 1; n <= 15; n++) tbl[n] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0};
    for (int k = 0; k < 6; k++) tbl[3 + 2 * k] = '{1'b0, 1'b0, 1'b0, 1'b1, aceito[k]};
    for (int k = 0; k < 6; k++) tbl[3 + 2 * k].v = 1'b1;
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    start = 1'b1;
    msg_sel = 2'd0;
    for (int n = 1; n <= 15; n++) begin
      tick();
      start = 1'b0;
      chk($sformatf("aceito_cyc%0d", n),
          {char_valid, out_clear, done, busy, char_valid ? char_out : 4'd0},
          {tbl[n].v, tbl[n].c, tbl[n].d, tbl[n].b, tbl[n].ch});
    end

    // Stall three cycles on character 2
    start = 1'b1;
    msg_sel = 2'd0;
    for (int n = 0; n < 7; n++) begin
      tick();
      start = 1'b0;
    end
    chk("stall_pre", {char_valid, char_out, counter_caracter}, {1'b1, 4'd3, 4'd2});
    char_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("stall_hold", {char_valid, out_clear, char_out, counter_caracter},
          {1'b1, 1'b0, 4'd3, 4'd2});
    end
    char_ready = 1'b1;
    tick();
    chk("stall_fetch", {char_valid, counter_caracter}, {1'b0, 4'd3});
    tick();
    chk("stall_resume", {char_valid, char_out}, {1'b1, 4'd4});
    wait_idle("stall");

    // Length 0 and length 15 messages
    run_msg(2'd1, "len0", nc, li);
    chk("len0_count", nc, 1);
    chk("len0_idx", li, 4'd0);
    run_msg(2'd2, "len15", nc, li);
    chk("len15_count", nc, 16);
    chk("len15_idx", li, 4'd15);

    // Length change after clear handshake has no effect
    run_msg(2'd3, "lenchg", nc, li);
    chk("lenchg_count", nc, 7);
    lens[3] = 4'd6;

    // Abort during SEND of index 3
    start = 1'b1;
    msg_sel = 2'd0;
    for (int n = 0; n < 9; n++) begin
      tick();
      start = 1'b0;
    end
    chk("abort_pre", {char_valid, char_out, counter_caracter}, {1'b1, 4'd4, 4'd3});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_post", {char_valid, busy, done, counter_caracter}, '0);
    sd = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done || busy) sd++;
    end
    chk("abort_no_done", sd, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_replay", {char_valid, out_clear, char_out}, {1'b1, 1'b1, 4'd0});
    wait_idle("replay");

    // Start and abort together in idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", {busy, char_valid}, 2'b00);

    // Start while busy ignored; reset during FETCH
    start = 1'b1;
    msg_sel = 2'd2;
    tick();
    msg_sel = 2'd3;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", {msg_id, char_valid, busy}, {2'd2, 1'b0, 1'b1});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid",
        {msg_id, counter_caracter, char_out, out_clear, char_valid, busy, done},
        '0);
    sd = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (done || busy || char_valid) sd++;
    end
    chk("reset_quiet", sd, 0);

    // Randomized run against a transaction-level model
    m_busy = 1'b0;
    m_final = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pv = char_valid;
      pclr = out_clear;
      pc = char_out;
      rdy = ($urandom % 4) != 0;
      st = ($urandom % 8) == 0;
      ab = ($urandom % 60) == 0;
      ms = 2'($urandom % 4);
      char_ready = rdy;
      start = st;
      abort = ab;
      msg_sel = ms;
      tick();
      hs = pv && rdy;
      if (ab && m_busy) begin
        m_busy = 1'b0;
        m_final = 1'b0;
        q.delete();
      end else if (m_final) begin
        m_final = 1'b0;
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (st && !ab) begin
          m_busy = 1'b1;
          q.push_back({1'b1, 4'd0});
          for (int i = 0; i <= int'(lens[ms]); i++) q.push_back({1'b0, rom[ms][i]});
        end
      end else if (hs) begin
        if (q.size() == 0) begin
          chk("rnd_extra_xfer", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_xfer", {pclr, pc}, e);
          if (q.size() == 0) m_final = 1'b1;
        end
      end
      chk("rnd_busy_done", {busy, done}, {m_busy, m_final});
      if (!m_busy) chk("rnd_idle_valid", char_valid, 1'b0);
      if (pv && !rdy && !ab && m_busy)
        chk("rnd_stable", {char_valid, out_clear, char_out}, {1'b1, pclr, pc});
    end
    start = 1'b0;
    abort = 1'b0;
    char_ready = 1'b1;
    nt = 0;
    wait_idle("rnd_end");
    nt = nt + 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
